// File: rtl/scoreboard_regfile.sv
// rtl/scoreboard_regfile.sv - register file with writeback bypass, busy-bit scoreboard and ecall halt detect
module scoreboard_regfile #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter logic [XLEN-1:0] SP_INIT = 32'h2ffc,
  parameter int HALT_REG = 17,
  parameter int HALT_CODE = 10,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rs_addr,
  output logic [NREAD*XLEN-1:0] rs_dout,
  output logic [NREAD-1:0]      rs_busy,
  input  logic [NREAD-1:0]      rs_used,
  input  logic                  wb_en,
  input  logic [AW-1:0]         wb_addr,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  is_ecall,
  output logic                  is_halted,
  output logic                  stall
);

  localparam logic [AW-1:0] HALT_A = AW'(HALT_REG);

  logic [XLEN-1:0]  rf [NREGS];
  logic [NREGS-1:0] busy;
  logic             halted;
  logic             wb_live;
  logic             iss_live;

  // Register 0 is hardwired: it never accepts data and never becomes busy.
  assign wb_live  = wb_en && (wb_addr != '0);
  assign iss_live = iss_en && (iss_addr != '0);

  for (genvar k = 0; k < NREAD; k++) begin : g_port
    logic [AW-1:0] a;
    logic          hit;
    assign a   = rs_addr[k*AW +: AW];
    assign hit = wb_live && (wb_addr == a);
    assign rs_dout[k*XLEN +: XLEN] = (a == '0) ? '0 : (hit ? wb_data : rf[a]);
    assign rs_busy[k] = busy[a] && !hit;
  end

  assign stall = |(rs_used & rs_busy);

  // The halt check sees the same bypassed view as a read port would.
  logic            halt_hit;
  logic            halt_busy;
  logic [XLEN-1:0] halt_val;
  logic            halt_now;

  assign halt_hit  = wb_live && (wb_addr == HALT_A);
  assign halt_val  = (HALT_A == '0) ? '0 : (halt_hit ? wb_data : rf[HALT_A]);
  assign halt_busy = busy[HALT_A] && !halt_hit;
  assign halt_now  = is_ecall && !halt_busy && (halt_val == XLEN'(HALT_CODE));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
      rf[2]  <= SP_INIT;
      busy   <= '0;
      halted <= 1'b0;
    end else begin
      if (wb_live) begin
        rf[wb_addr]   <= wb_data;
        busy[wb_addr] <= 1'b0;
      end
      // A new producer issued in the same cycle overrides the clear above.
      if (iss_live) begin
        busy[iss_addr] <= 1'b1;
      end
      if (halt_now) begin
        halted <= 1'b1;
      end
    end
  end

  assign is_halted = halted;

endmodule
